player_health: RTL and testbench

Tracks the player's health for the punch-out game and drives the `health` input of the player control FSM. It consumes enemy punch events and the control FSM's `can_be_hit` flag. It applies damage with saturation and enforces a post-hit invulnerability window. It declares the knockout that moves the control FSM to its dead state.

---
 rtl/punch_pkg.sv | 24 ++
 rtl/cycle_timer.sv | 29 ++
 rtl/player_health.sv | 110 +++++++++++
 tb/tb_player_health.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/punch_pkg.sv
// Shared definitions for the punch-out game: player health state encoding,
// health width, default damage values and a saturating subtract helper.
package punch_pkg;

  localparam int HEALTH_W             = 4;
  localparam int DEFAULT_MAX_HEALTH   = 10;
  localparam int DEFAULT_LIGHT_DAMAGE = 1;
  localparam int DEFAULT_HEAVY_DAMAGE = 3;

  typedef enum logic [1:0] {
    ST_ALIVE    = 2'd0,
    ST_COOLDOWN = 2'd1,
    ST_DEAD     = 2'd2
  } health_state_e;

  // Subtract with one extra bit so an underflow shows up as a borrow and clamps to 0.
  function automatic logic [HEALTH_W-1:0] sat_sub(input logic [HEALTH_W-1:0] a,
                                                  input logic [HEALTH_W-1:0] b);
    logic [HEALTH_W:0] diff;
    diff = {1'b0, a} - {1'b0, b};
    return diff[HEALTH_W] ? '0 : diff[HEALTH_W-1:0];
  endfunction

endpackage

// File: rtl/cycle_timer.sv
// Loadable down-counter that stops at zero; used as the post-hit invulnerability timer.
module cycle_timer #(
  parameter int WIDTH = 4
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             enable,
  output logic             zero
);

  logic [WIDTH-1:0] count_q;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of every other register.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= load_value;
    end else if (enable && count_q != '0) begin
      count_q <= count_q - 1'b1;
    end
  end

  assign zero = (count_q == '0);

endmodule

// File: rtl/player_health.sv
// Player health tracker: saturating damage, blocked-punch pulses, a post-hit
// invulnerability window and knockout detection.
module player_health
  import punch_pkg::*;
#(
  parameter int MAX_HEALTH      = DEFAULT_MAX_HEALTH,
  parameter int LIGHT_DAMAGE    = DEFAULT_LIGHT_DAMAGE,
  parameter int HEAVY_DAMAGE    = DEFAULT_HEAVY_DAMAGE,
  parameter int COOLDOWN_CYCLES = 12_500_000
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                enemy_punch,
  input  logic                enemy_heavy,
  input  logic                can_be_hit,
  input  logic                new_round,
  output logic [HEALTH_W-1:0] health,
  output logic                dead,
  output logic                hit_flash,
  output logic                blocked_hit
);

  localparam int TIMER_W = (COOLDOWN_CYCLES > 1) ? $clog2(COOLDOWN_CYCLES) : 1;
  localparam logic [TIMER_W-1:0]  RELOAD     = TIMER_W'(COOLDOWN_CYCLES - 1);
  localparam logic [HEALTH_W-1:0] FULL       = HEALTH_W'(MAX_HEALTH);
  localparam logic [HEALTH_W-1:0] LIGHT_DMG  = HEALTH_W'(LIGHT_DAMAGE);
  localparam logic [HEALTH_W-1:0] HEAVY_DMG  = HEALTH_W'(HEAVY_DAMAGE);

  health_state_e       state_q, state_d;
  logic [HEALTH_W-1:0] health_q, health_d;
  logic                blocked_q, blocked_d;
  logic                timer_load, timer_enable, timer_zero;
  logic [TIMER_W-1:0]  timer_value;
  logic                hit;
  logic [HEALTH_W-1:0] damage;

  assign hit    = enemy_punch | enemy_heavy;
  assign damage = enemy_heavy ? HEAVY_DMG : LIGHT_DMG;

  // NOTE: every signal written here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d      = state_q;
    health_d     = health_q;
    blocked_d    = 1'b0;
    timer_load   = 1'b0;
    timer_value  = '0;
    timer_enable = 1'b0;

    if (new_round) begin
      state_d    = ST_ALIVE;
      health_d   = FULL;
      timer_load = 1'b1;
    end else begin
      unique case (state_q)
        ST_ALIVE: begin
          if (hit) begin
            if (can_be_hit) begin
              health_d = sat_sub(health_q, damage);
              if (health_d == '0) begin
                state_d = ST_DEAD;
              end else begin
                state_d     = ST_COOLDOWN;
                timer_load  = 1'b1;
                timer_value = RELOAD;
              end
            end else begin
              blocked_d = 1'b1;
            end
          end
        end
        ST_COOLDOWN: begin
          if (timer_zero) state_d = ST_ALIVE;
          else            timer_enable = 1'b1;
        end
        ST_DEAD: ;
        default: state_d = ST_ALIVE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q   <= ST_ALIVE;
      health_q  <= FULL;
      blocked_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      health_q  <= health_d;
      blocked_q <= blocked_d;
    end
  end

  cycle_timer #(
    .WIDTH(TIMER_W)
  ) u_cooldown (
    .clock      (clock),
    .reset_n    (reset_n),
    .load       (timer_load),
    .load_value (timer_value),
    .enable     (timer_enable),
    .zero       (timer_zero)
  );

  assign health      = health_q;
  assign blocked_hit = blocked_q;
  assign dead        = (state_q == ST_DEAD);
  assign hit_flash   = (state_q == ST_COOLDOWN);

endmodule

// File: tb/tb_player_health.sv
// Self-checking bench for player_health: directed scenarios with literal
// expectations plus a randomized run against a behavioural health model.
module tb_player_health;

  localparam int COOL  = 4;
  localparam int MAXH  = 10;
  localparam int LIGHT = 1;
  localparam int HEAVY = 3;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       enemy_punch = 1'b0;
  logic       enemy_heavy = 1'b0;
  logic       can_be_hit = 1'b1;
  logic       new_round = 1'b0;
  logic [3:0] health;
  logic       dead, hit_flash, blocked_hit;

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model: health as an integer, remaining flash cycles as a count.
  int m_health    = MAXH;
  int m_cool_left = 0;
  bit m_dead      = 1'b0;
  bit m_blocked   = 1'b0;

  player_health #(
    .MAX_HEALTH      (MAXH),
    .LIGHT_DAMAGE    (LIGHT),
    .HEAVY_DAMAGE    (HEAVY),
    .COOLDOWN_CYCLES (COOL)
  ) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .enemy_punch (enemy_punch),
    .enemy_heavy (enemy_heavy),
    .can_be_hit  (can_be_hit),
    .new_round   (new_round),
    .health      (health),
    .dead        (dead),
    .hit_flash   (hit_flash),
    .blocked_hit (blocked_hit)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input int actual, input int expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic model_step();
    int dmg;
    m_blocked = 1'b0;
    if (!reset_n || new_round) begin
      m_health    = MAXH;
      m_cool_left = 0;
      m_dead      = 1'b0;
    end else if (m_dead) begin
      // knocked out: nothing but a new round or reset changes anything
    end else if (m_cool_left > 0) begin
      m_cool_left--;
    end else if (enemy_punch || enemy_heavy) begin
      dmg = enemy_heavy ? HEAVY : LIGHT;
      if (can_be_hit) begin
        m_health = (m_health > dmg) ? m_health - dmg : 0;
        if (m_health == 0) m_dead = 1'b1;
        else               m_cool_left = COOL;
      end else begin
        m_blocked = 1'b1;
      end
    end
  endtask

  // Compare process: model advances on each edge, outputs checked 1 time unit later.
  always @(posedge clock) begin
    model_step();
    #1;
    check("model_health",  int'(health),      m_health);
    check("model_dead",    int'(dead),        int'(m_dead));
    check("model_flash",   int'(hit_flash),   int'(m_cool_left > 0));
    check("model_blocked", int'(blocked_hit), int'(m_blocked));
  end

  // Drive one cycle of inputs at the falling edge, then wait past the next rising edge.
  task automatic tick(input bit p, input bit h, input bit cbh, input bit nr);
    @(negedge clock);
    enemy_punch = p;
    enemy_heavy = h;
    can_be_hit  = cbh;
    new_round   = nr;
    @(posedge clock);
    #2;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(0, 0, 1, 0);
  endtask

  initial begin
    // Reset, then idle
    reset_n = 1'b0;
    idle(2);
    @(negedge clock);
    reset_n = 1'b1;
    idle(3);
    check("reset_health",  int'(health),      10);
    check("reset_dead",    int'(dead),        0);
    check("reset_flash",   int'(hit_flash),   0);
    check("reset_blocked", int'(blocked_hit), 0);

    // Light hit, then a punch inside the invulnerability window
    tick(1, 0, 1, 0);
    check("light_health", int'(health), 9);
    check("flash_c1", int'(hit_flash), 1);
    idle(1);
    check("flash_c2", int'(hit_flash), 1);
    tick(1, 0, 1, 0);
    check("cool_ignore_health", int'(health), 9);
    check("flash_c3", int'(hit_flash), 1);
    idle(1);
    check("flash_c4", int'(hit_flash), 1);
    idle(1);
    check("flash_end", int'(hit_flash), 0);

    // Simultaneous punch and heavy: heavy wins
    tick(1, 1, 1, 0);
    check("both_health", int'(health), 6);
    idle(4);

    // Blocked heavy, then back-to-back blocks
    tick(0, 1, 0, 0);
    check("block_pulse",  int'(blocked_hit), 1);
    check("block_health", int'(health),      6);
    check("block_flash",  int'(hit_flash),   0);
    idle(1);
    check("block_pulse_end", int'(blocked_hit), 0);
    tick(0, 1, 0, 0);
    check("b2b_first", int'(blocked_hit), 1);
    tick(1, 0, 0, 0);
    check("b2b_second", int'(blocked_hit), 1);
    idle(1);

    // Walk health down to 2, then a lethal heavy saturates at 0
    tick(0, 1, 1, 0);
    check("to3_health", int'(health), 3);
    idle(4);
    tick(1, 0, 1, 0);
    check("to2_health", int'(health), 2);
    idle(4);
    tick(0, 1, 1, 0);
    check("ko_health", int'(health),    0);
    check("ko_dead",   int'(dead),      1);
    check("ko_flash",  int'(hit_flash), 0);
    tick(1, 0, 1, 0);
    tick(0, 1, 0, 0);
    check("dead_ignore_health",  int'(health),      0);
    check("dead_ignore_blocked", int'(blocked_hit), 0);
    check("dead_stays",          int'(dead),        1);

    // New round coincident with a heavy punch
    tick(0, 1, 1, 1);
    check("nr_health", int'(health),    10);
    check("nr_dead",   int'(dead),      0);
    check("nr_flash",  int'(hit_flash), 0);

    // Reset in the middle of a cooldown
    tick(1, 0, 1, 0);
    check("pre_rst_flash", int'(hit_flash), 1);
    @(negedge clock);
    reset_n = 1'b0;
    tick(0, 0, 1, 0);
    check("rst_cool_health", int'(health),    10);
    check("rst_cool_flash",  int'(hit_flash), 0);
    @(negedge clock);
    reset_n = 1'b1;

    // Randomized run against the model
    for (int i = 0; i < 4000; i++) begin
      bit p, h, cbh, nr;
      p   = ($urandom_range(0, 3) == 0);
      h   = ($urandom_range(0, 5) == 0);
      cbh = ($urandom_range(0, 3) != 0);
      nr  = ($urandom_range(0, 39) == 0);
      @(negedge clock);
      reset_n = ($urandom_range(0, 299) != 0);
      enemy_punch = p;
      enemy_heavy = h;
      can_be_hit  = cbh;
      new_round   = nr;
      @(posedge clock);
      #2;
    end

    @(negedge clock);
    reset_n = 1'b1;
    enemy_punch = 1'b0;
    enemy_heavy = 1'b0;
    new_round   = 1'b0;
    idle(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
